// File: rtl/dac_pkg.sv
// Shared types and sizing helpers for the audio DAC serializer.
package dac_pkg;

  typedef enum logic [1:0] {FMT_LJ, FMT_I2S, FMT_RJ} fmt_e;

  function automatic int frame_bits(input int channels, input int slot_w);
    return channels * slot_w;
  endfunction

endpackage

// File: rtl/dac_serializer_if.sv
// Upstream frame handshake: one frame request per frame period plus underrun pulse.
interface dac_serializer_if #(
  parameter int CHANNELS = 2,
  parameter int SAMPLE_W = 24
);
  logic                         i_valid;
  logic [CHANNELS*SAMPLE_W-1:0] i_data;
  logic                         i_mute;
  logic                         o_ready;
  logic                         o_underrun;

  modport master (output i_valid, i_data, i_mute, input o_ready, o_underrun);
  modport slave  (input i_valid, i_data, i_mute, output o_ready, o_underrun);
endinterface

// File: rtl/dac_bck_gen.sv
// Bit-clock generator: divides i_clk36 and flags the cycle before each BCK edge.
module dac_bck_gen #(
  parameter int BCK_DIV = 8
) (
  input  logic i_clk36,
  input  logic i_rst36,
  output logic o_bck,
  output logic o_rise,
  output logic o_fall
);
  localparam int            DW      = (BCK_DIV > 1) ? $clog2(BCK_DIV) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(BCK_DIV - 1);

  logic [DW-1:0] div_q, div_d;
  logic          bck_q, en_q, tick;

  // en_q keeps BCK_DIV == 1 from ticking while reset is still held
  assign tick  = en_q && (div_q == DIV_MAX);
  assign div_d = (div_q == DIV_MAX) ? '0 : div_q + 1'b1;

  always_ff @(posedge i_clk36) begin
    if (i_rst36) begin
      div_q <= '0;
      bck_q <= 1'b0;
      en_q  <= 1'b0;
    end else begin
      div_q <= div_d;
      en_q  <= 1'b1;
      if (tick) bck_q <= ~bck_q;
    end
  end

  assign o_bck  = bck_q;
  assign o_rise = tick && !bck_q;
  assign o_fall = tick &&  bck_q;

endmodule

// File: rtl/dac_serializer.sv
// Audio DAC serial driver: pulls one PCM frame per frame period and shifts it out
// MSB-first as BCK/LRCK/DATA in LJ, I2S or RJ format, including TDM layouts.
module dac_serializer
  import dac_pkg::*;
#(
  parameter int   SAMPLE_W      = 24,
  parameter int   SLOT_W        = 24,
  parameter int   CHANNELS      = 2,
  parameter int   BCK_DIV       = 8,
  parameter fmt_e FORMAT        = FMT_LJ,
  parameter bit   UNDERRUN_ZERO = 1'b0
) (
  input  logic            i_clk36,
  input  logic            i_rst36,
  dac_serializer_if.slave frm,
  output logic            o_bck,
  output logic            o_lrck,
  output logic            o_data
);
  localparam int            FB    = frame_bits(CHANNELS, SLOT_W);
  localparam int            BW    = $clog2(FB);
  localparam logic [BW-1:0] LAST  = BW'(FB - 1);
  localparam logic [BW-1:0] SLOT1 = BW'(SLOT_W);

  if (SLOT_W < SAMPLE_W) begin : g_chk_slot
    $error("dac_serializer: SLOT_W must be >= SAMPLE_W");
  end
  if ((CHANNELS < 2) || (CHANNELS % 2 != 0)) begin : g_chk_ch
    $error("dac_serializer: CHANNELS must be even and >= 2");
  end

  logic rise, fall;

  dac_bck_gen #(.BCK_DIV(BCK_DIV)) u_bck (
    .i_clk36 (i_clk36),
    .i_rst36 (i_rst36),
    .o_bck   (o_bck),
    .o_rise  (rise),
    .o_fall  (fall)
  );

  logic [CHANNELS*SAMPLE_W-1:0] hold_q;
  logic [FB-1:0]                frame, sh_q, sh_d;
  logic [BW-1:0]                bit_q, bit_d;
  logic                         wrap, ready, lj_bit, lrck_d;
  logic                         und_q, dly_q, data_q, lrck_q;

  // Slot layout: sample left-aligned (LJ/I2S) or right-aligned (RJ) in its slot
  for (genvar c = 0; c < CHANNELS; c++) begin : g_slot
    logic [SLOT_W-1:0] smp;
    assign smp = SLOT_W'(hold_q[(CHANNELS-1-c)*SAMPLE_W +: SAMPLE_W]);
    assign frame[(CHANNELS-1-c)*SLOT_W +: SLOT_W] =
      (FORMAT == FMT_RJ) ? smp : smp << (SLOT_W - SAMPLE_W);
  end

  assign wrap   = (bit_q == LAST);
  assign ready  = rise && wrap;
  assign bit_d  = wrap ? '0 : bit_q + 1'b1;
  assign lj_bit = wrap ? frame[FB-1] : sh_q[FB-1];
  assign sh_d   = wrap ? frame << 1 : sh_q << 1;

  // LRCK is computed for the bit about to be presented (bit_d)
  always_comb begin
    lrck_d = 1'b0;
    if (CHANNELS == 2)
      lrck_d = (FORMAT == FMT_I2S) ? (bit_d >= SLOT1) : (bit_d < SLOT1);
    else
      lrck_d = (FORMAT == FMT_I2S) ? (bit_d == LAST) : (bit_d == '0);
  end

  always_ff @(posedge i_clk36) begin
    if (i_rst36) begin
      hold_q <= '0;
      und_q  <= 1'b0;
      bit_q  <= LAST;
      sh_q   <= '0;
      dly_q  <= 1'b0;
      data_q <= 1'b0;
      lrck_q <= 1'b0;
    end else begin
      und_q <= ready && !frm.i_valid && !frm.i_mute;
      if (ready) begin
        if (frm.i_mute)        hold_q <= '0;
        else if (frm.i_valid)  hold_q <= frm.i_data;
        else if (UNDERRUN_ZERO) hold_q <= '0;
      end
      // I2S is the LJ stream one BCK late; dly_q carries the bit across frames
      if (fall) begin
        bit_q  <= bit_d;
        sh_q   <= sh_d;
        dly_q  <= lj_bit;
        data_q <= (FORMAT == FMT_I2S) ? dly_q : lj_bit;
        lrck_q <= lrck_d;
      end
    end
  end

  assign frm.o_ready    = ready;
  assign frm.o_underrun = und_q;
  assign o_lrck         = lrck_q;
  assign o_data         = data_q;

endmodule

// File: tb/tb_dac_serializer.sv
// Directed bench: four serializer configurations share clock/reset; serial bits are
// captured on every BCK rise and compared against hand-computed frames.
module tb_dac_serializer;
  import dac_pkg::*;

  logic clk, rst, vld, mute;
  int   nvec = 0, nerr = 0;

  dac_serializer_if #(.CHANNELS(2), .SAMPLE_W(24)) f0 ();
  dac_serializer_if #(.CHANNELS(2), .SAMPLE_W(24)) f1 ();
  dac_serializer_if #(.CHANNELS(2), .SAMPLE_W(16)) f2 ();
  dac_serializer_if #(.CHANNELS(8), .SAMPLE_W(24)) f3 ();

  logic bck0, lr0, d0, bck1, lr1, d1, bck2, lr2, d2, bck3, lr3, d3;

  assign f0.i_valid = vld;  assign f0.i_mute = mute;
  assign f1.i_valid = vld;  assign f1.i_mute = mute;
  assign f2.i_valid = vld;  assign f2.i_mute = mute;
  assign f3.i_valid = 1'b1; assign f3.i_mute = 1'b0;
  assign f0.i_data = 48'h800001_7FFFFE;
  assign f1.i_data = 48'h800001_7FFFFE;
  assign f2.i_data = 32'hFFFF_0001;
  assign f3.i_data = {24'h5A5A00, 24'h5A5A01, 24'h5A5A02, 24'h5A5A03,
                      24'h5A5A04, 24'h5A5A05, 24'h5A5A06, 24'h5A5A07};

  dac_serializer u0 (.i_clk36(clk), .i_rst36(rst), .frm(f0), .o_bck(bck0), .o_lrck(lr0), .o_data(d0));
  dac_serializer #(.FORMAT(FMT_I2S), .UNDERRUN_ZERO(1'b1))
    u1 (.i_clk36(clk), .i_rst36(rst), .frm(f1), .o_bck(bck1), .o_lrck(lr1), .o_data(d1));
  dac_serializer #(.SAMPLE_W(16), .FORMAT(FMT_RJ))
    u2 (.i_clk36(clk), .i_rst36(rst), .frm(f2), .o_bck(bck2), .o_lrck(lr2), .o_data(d2));
  dac_serializer #(.CHANNELS(8), .SLOT_W(32), .BCK_DIV(1))
    u3 (.i_clk36(clk), .i_rst36(rst), .frm(f3), .o_bck(bck3), .o_lrck(lr3), .o_data(d3));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Serial capture: one entry per BCK rise since reset release (entry 0 precedes frame 0)
  logic qd0[$], ql0[$], qd1[$], ql1[$], qd2[$], qd3[$], ql3[$];
  logic pb0 = 1'b0, pb3 = 1'b0;

  always @(negedge clk) begin
    if (rst) begin
      qd0.delete(); ql0.delete(); qd1.delete(); ql1.delete();
      qd2.delete(); qd3.delete(); ql3.delete();
    end else begin
      if (bck0 && !pb0) begin
        qd0.push_back(d0); ql0.push_back(lr0);
        qd1.push_back(d1); ql1.push_back(lr1);
        qd2.push_back(d2);
      end
      if (bck3 && !pb3) begin
        qd3.push_back(d3); ql3.push_back(lr3);
      end
    end
    pb0 <= bck0;
    pb3 <= bck3;
  end

  function automatic logic [255:0] grab(input logic q[$], input int base, input int len);
    logic [255:0] r = '0;
    for (int i = 0; i < len; i++)
      r = {r[254:0], (base + i < q.size()) ? q[base+i] : 1'bx};
    return r;
  endfunction

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: got %0h need %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_rdy(input int sel, input int lim, output int n);
    logic r;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      r = (sel == 3) ? f3.o_ready : f0.o_ready;
    end while (r !== 1'b1 && n < lim);
    chk("ready_seen", 256'(r), 256'(1));
  endtask

  logic [19:0] outs;
  assign outs = {f0.o_ready, f0.o_underrun, bck0, lr0, d0, f1.o_ready, f1.o_underrun, bck1, lr1, d1,
                 f2.o_ready, f2.o_underrun, bck2, lr2, d2, f3.o_ready, f3.o_underrun, bck3, lr3, d3};

  initial begin
    int n;
    rst = 1'b1; vld = 1'b1; mute = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs", 256'(outs), 256'(0));

    rst = 1'b0;
    wait_rdy(0, 100, n);
    chk("first_ready", 256'(n), 256'(7));

    // BCK period measured between two rising edges
    n = 0;
    while (bck0 !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    n = 0;
    do begin @(negedge clk); n++; end while (bck0 !== 1'b0 && n < 100);
    do begin @(negedge clk); n++; end while (bck0 !== 1'b1 && n < 100);
    chk("bck_period", 256'(n), 256'(16));

    wait_rdy(0, 2000, n);                     // ready 1
    @(posedge clk); #1 vld = 1'b0;            // ready 2 becomes an underrun
    wait_rdy(0, 2000, n);
    chk("ready_period", 256'(n), 256'(768));
    chk("und_before", 256'({f0.o_underrun, f1.o_underrun, f2.o_underrun}), 256'(0));
    @(negedge clk);
    chk("und_pulse", 256'({f0.o_underrun, f1.o_underrun, f2.o_underrun}), 256'(3'b111));
    @(negedge clk);
    chk("und_after", 256'({f0.o_underrun, f1.o_underrun, f2.o_underrun}), 256'(0));

    vld = 1'b1; mute = 1'b1;                  // ready 3 loads a muted frame
    wait_rdy(0, 2000, n);
    @(negedge clk);
    chk("mute_no_und", 256'({f0.o_underrun, f1.o_underrun, f2.o_underrun}), 256'(0));
    mute = 1'b0;

    chk("lj_f0_data",  grab(qd0, 1,       48), 256'(48'h800001_7FFFFE));
    chk("lj_f0_lrck",  grab(ql0, 1,       48), 256'(48'hFFFFFF_000000));
    chk("lj_f2_rept",  grab(qd0, 1 + 96,  48), 256'(48'h800001_7FFFFE));
    chk("i2s_f0_data", grab(qd1, 1,       48), 256'(48'h400000_BFFFFF));
    chk("i2s_f0_lrck", grab(ql1, 1,       48), 256'(48'h000000_FFFFFF));
    chk("i2s_f1_data", grab(qd1, 1 + 48,  48), 256'(48'h400000_BFFFFF));
    chk("i2s_f2_zero", grab(qd1, 1 + 96,  48), 256'(0));
    chk("rj_f0_data",  grab(qd2, 1,       48), 256'(48'h00FFFF_000001));
    chk("tdm_f0_data", grab(qd3, 1, 256),
        256'h5A5A0000_5A5A0100_5A5A0200_5A5A0300_5A5A0400_5A5A0500_5A5A0600_5A5A0700);
    chk("tdm_f0_lrck", grab(ql3, 1, 256), {1'b1, 255'b0});
    chk("tdm_f1_ch7",  grab(qd3, 1 + 256 + 224, 32), 256'(32'h5A5A0700));

    // Into bit 30 of the muted frame, then reset mid-frame
    repeat (489) @(negedge clk);
    chk("mute_slot0", grab(qd0, 1 + 144, 24), 256'(0));
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_outs", 256'(outs), 256'(0));
    rst = 1'b0;
    wait_rdy(0, 100, n);
    chk("rst_ready", 256'(n), 256'(7));

    wait_rdy(3, 2000, n);
    @(posedge clk); #1;
    wait_rdy(3, 2000, n);
    chk("tdm_period", 256'(n), 256'(512));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
